back_icon_tx_arbiter: RTL and testbench
=======================================

// Module: back_icon_tx_arbiter
// PURPOSE
// - Round-robin arbiter sharing each EU's single tx buffer among the interconnect channels.
// - Sits between the icon controller's per-channel current instructions and the icon datapath.
// - Replaces fixed lowest-channel-wins priority with a registered, starvation-free grant per source EU.
// - A channel keeps its grant until its transfer completes.
// PARAMETERS
// - NUM_ICON_CHANNELS  4   channels competing for tx buffers
// - NUM_EUS            8   source exec units, one tx buffer each
// - MAX_HOLD_CYCLES    15  watchdog limit, used only with BACK_ICON_TX_ARB_TIMEOUT_EN
// PORTS
// - clk          in   1                        clock
// - reset_n      in   1                        synchronous reset, active-low
// - req_valid_i  in   [NUM_ICON_CHANNELS]x1    channel has a valid instr needing its src EU tx buffer
// - req_euidx_i  in   [NUM_ICON_CHANNELS]x$clog2(NUM_EUS)  src EU index of that instr
// - done_i       in   [NUM_ICON_CHANNELS]x1    channel's transfer complete (all receivers succeeded)
// - grant_o      out  [NUM_ICON_CHANNELS]x1    registered: channel owns its requested tx buffer
// - busy_eus_o   out  NUM_EUS                  registered: bit e set while EU e is owned
// - timeout_o    out  [NUM_ICON_CHANNELS]x1    1-cycle pulse on forced release; tied 0 without macro
// BEHAVIOUR
// - Reset: every EU IDLE, rr_ptr[e]=0, hold_cnt[e]=0. grant_o, busy_eus_o and timeout_o are all 0.
// - Per EU e there is a 2-state FSM, IDLE and OWNED(owner), plus rr_ptr[e] of width $clog2(NUM_ICON_CHANNELS).
// - cand(e) is the set of ch with req_valid_i[ch] && req_euidx_i[ch]==e.
// - IDLE -> OWNED:
//   - Taken when cand(e) is non-empty.
//   - The owner is the first ch in cand(e) searching cyclically from rr_ptr[e].
//   - grant_o[owner] rises at the next edge, so latency from request to grant is 1 cycle.
// - Release condition, OWNED(o):
//   - done_i[o] is high, OR
//   - req_valid_i[o] is low, OR
//   - req_euidx_i[o] != e (protocol violation, treated as a drop).
// - On release at an edge:
//   - rr_ptr[e] <= (o+1) mod NUM_ICON_CHANNELS.
//   - If cand(e) minus {o} is non-empty: hand over in the same edge to the first candidate searching from o+1.
//     The new grant is seen the next cycle with no bubble.
//   - Otherwise: go to IDLE.
// - Ownership constraints:
//   - A channel owns at most one EU, since it requests one idx.
//   - Different EUs arbitrate independently, so up to min(NUM_ICON_CHANNELS,NUM_EUS) grants can be active at once.
// - grant_o[ch]=1 iff some EU is OWNED(ch). It drops the edge after release.
// - Requests that arrive or leave while another channel owns the EU only affect the next selection.
// - Simultaneous done_i and new requests follow the handover rule above. A done_i from a non-owner is ignored.
// - rr_ptr wraps modulo NUM_ICON_CHANNELS. Non-power-of-2 counts must wrap correctly, e.g. 3 -> 0 for N=3.
// - reset_n low mid-grant: all state returns to reset values at that edge, and outstanding grants are lost.
// CONFIGURATION
// - BACK_ICON_TX_ARB_TIMEOUT_EN defined:
//   - hold_cnt[e] counts cycles in OWNED. It saturates at MAX_HOLD_CYCLES and clears on release or handover.
//   - When hold_cnt[e]==MAX_HOLD_CYCLES and the release condition is false, a forced release occurs.
//     It uses normal release/handover rules, and timeout_o[owner] pulses for 1 cycle at that edge.
//   - The forced channel may re-win only when rr order reaches it again.
// - Macro not defined: no counters, timeout_o=0, grants are held indefinitely.
// TESTING
// - Reset 3 cycles with all reqs high: grant_o=0000, busy_eus_o=0, timeout_o=0 throughout reset.
// - ch1 req EU2 at cycle 0: grant_o=0010 and busy_eus_o[2]=1 at cycle 1. done_i[1] at cycle 4: both 0 at cycle 5.
// - ch0,ch1,ch3 all req EU5; each pulses done 2 cycles after grant:
//   - grant order 0,1,3,0 with no idle cycle between owners.
// - ch0 req EU1, ch2 req EU6 at the same time: both granted at cycle 1 with grant_o=0101, busy_eus_o=01000010.
// - ch2 owns EU3 and changes req_euidx_i to 4: EU3 is released next edge; ch2 is granted EU4 via IDLE one cycle later.
// - TIMEOUT_EN with MAX_HOLD_CYCLES=15: ch0 holds EU0 with no done, ch1 waiting.
//   - timeout_o[0] pulses when hold_cnt hits 15, then grant_o=0010 the next cycle.
//   - Without the macro, ch0 keeps its grant for 100 cycles.

Source files
------------

// File: rtl/back_icon_tx_arbiter_if.sv
// Channel/arbiter handshake bundle for the icon tx-buffer arbiter.
// master = icon controller side, slave = arbiter side.
interface back_icon_tx_arbiter_if #(
    parameter int NUM_ICON_CHANNELS = 4,
    parameter int NUM_EUS           = 8
);
    localparam int EU_W = (NUM_EUS > 1) ? $clog2(NUM_EUS) : 1;

    logic [NUM_ICON_CHANNELS-1:0]           req_valid_i;
    logic [NUM_ICON_CHANNELS-1:0][EU_W-1:0] req_euidx_i;
    logic [NUM_ICON_CHANNELS-1:0]           done_i;
    logic [NUM_ICON_CHANNELS-1:0]           grant_o;
    logic [NUM_EUS-1:0]                     busy_eus_o;
    logic [NUM_ICON_CHANNELS-1:0]           timeout_o;

    modport master (
        output req_valid_i, req_euidx_i, done_i,
        input  grant_o, busy_eus_o, timeout_o
    );

    modport slave (
        input  req_valid_i, req_euidx_i, done_i,
        output grant_o, busy_eus_o, timeout_o
    );
endinterface

// File: rtl/back_icon_tx_arbiter.sv
// Per-EU round-robin arbiter granting each EU's tx buffer to one icon channel at a time.
// Optional hold watchdog enabled by defining BACK_ICON_TX_ARB_TIMEOUT_EN.
module back_icon_tx_arbiter #(
    parameter int NUM_ICON_CHANNELS = 4,
    parameter int NUM_EUS           = 8,
    parameter int MAX_HOLD_CYCLES   = 15
) (
    input logic clk,
    input logic reset_n,
    back_icon_tx_arbiter_if.slave bus
);
    localparam int CH_W = (NUM_ICON_CHANNELS > 1) ? $clog2(NUM_ICON_CHANNELS) : 1;
    localparam int EU_W = (NUM_EUS > 1) ? $clog2(NUM_EUS) : 1;

    typedef enum logic {EU_IDLE, EU_OWNED} eu_state_t;
    typedef logic [CH_W-1:0] ch_idx_t;

    eu_state_t state_q [NUM_EUS];
    eu_state_t state_d [NUM_EUS];
    ch_idx_t   owner_q [NUM_EUS];
    ch_idx_t   owner_d [NUM_EUS];
    ch_idx_t   rr_q    [NUM_EUS];
    ch_idx_t   rr_d    [NUM_EUS];

    logic [NUM_ICON_CHANNELS-1:0] grant_q, grant_d;
    logic [NUM_EUS-1:0]           busy_q, busy_d;
    logic [NUM_ICON_CHANNELS-1:0] timeout_d;

`ifdef BACK_ICON_TX_ARB_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD_CYCLES + 1);
    logic [HOLD_W-1:0]            hold_q [NUM_EUS];
    logic [HOLD_W-1:0]            hold_d [NUM_EUS];
    logic [NUM_ICON_CHANNELS-1:0] timeout_q;
`endif

    // First set bit of cand searching cyclically from start; MSB flags a hit.
    function automatic logic [CH_W:0] pick_from(input logic [NUM_ICON_CHANNELS-1:0] cand,
                                                 input ch_idx_t start);
        logic    found;
        ch_idx_t sel;
        ch_idx_t probe;
        int      idx;
        found = 1'b0;
        sel   = '0;
        for (int k = 0; k < NUM_ICON_CHANNELS; k++) begin
            idx = int'(start) + k;
            if (idx >= NUM_ICON_CHANNELS) idx = idx - NUM_ICON_CHANNELS;
            probe = ch_idx_t'(idx);
            if (!found && cand[probe]) begin
                found = 1'b1;
                sel   = probe;
            end
        end
        return {found, sel};
    endfunction

    function automatic ch_idx_t wrap_inc(input ch_idx_t c);
        return (int'(c) + 1 >= NUM_ICON_CHANNELS) ? '0 : c + 1'b1;
    endfunction

    always_comb begin
        logic [NUM_ICON_CHANNELS-1:0] cand;
        logic [NUM_ICON_CHANNELS-1:0] cand_ex;
        logic [CH_W:0]                pick;
        logic                         rel;
        logic                         forced;
        ch_idx_t                      o;
        ch_idx_t                      nxt;

        state_d   = state_q;
        owner_d   = owner_q;
        rr_d      = rr_q;
        grant_d   = '0;
        busy_d    = '0;
        timeout_d = '0;
        cand      = '0;
        cand_ex   = '0;
        pick      = '0;
        rel       = 1'b0;
        forced    = 1'b0;
        o         = '0;
        nxt       = '0;
`ifdef BACK_ICON_TX_ARB_TIMEOUT_EN
        hold_d    = hold_q;
`endif

        for (int e = 0; e < NUM_EUS; e++) begin
            for (int ch = 0; ch < NUM_ICON_CHANNELS; ch++) begin
                cand[ch] = bus.req_valid_i[ch] && (bus.req_euidx_i[ch] == EU_W'(e));
            end
            o = owner_q[e];

            case (state_q[e])
                EU_IDLE: begin
                    pick = pick_from(cand, rr_q[e]);
                    if (pick[CH_W]) begin
                        state_d[e] = EU_OWNED;
                        owner_d[e] = pick[CH_W-1:0];
                    end
                end
                EU_OWNED: begin
                    // A dropped request or a changed EU index both count as the owner letting go.
                    rel = !cand[o] || bus.done_i[o];
`ifdef BACK_ICON_TX_ARB_TIMEOUT_EN
                    forced = !rel && (hold_q[e] == HOLD_W'(MAX_HOLD_CYCLES));
`else
                    forced = 1'b0;
`endif
                    if (rel || forced) begin
                        nxt       = wrap_inc(o);
                        rr_d[e]   = nxt;
                        cand_ex   = cand;
                        cand_ex[o] = 1'b0;
                        pick      = pick_from(cand_ex, nxt);
                        timeout_d[o] = forced;
                        if (pick[CH_W]) begin
                            owner_d[e] = pick[CH_W-1:0];
                        end else begin
                            state_d[e] = EU_IDLE;
                        end
`ifdef BACK_ICON_TX_ARB_TIMEOUT_EN
                        hold_d[e] = '0;
                    end else if (hold_q[e] != HOLD_W'(MAX_HOLD_CYCLES)) begin
                        hold_d[e] = hold_q[e] + 1'b1;
`endif
                    end
                end
                default: state_d[e] = EU_IDLE;
            endcase

            if (state_d[e] == EU_OWNED) begin
                grant_d[owner_d[e]] = 1'b1;
                busy_d[e]           = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int e = 0; e < NUM_EUS; e++) begin
                state_q[e] <= EU_IDLE;
                owner_q[e] <= '0;
                rr_q[e]    <= '0;
`ifdef BACK_ICON_TX_ARB_TIMEOUT_EN
                hold_q[e]  <= '0;
`endif
            end
            grant_q <= '0;
            busy_q  <= '0;
`ifdef BACK_ICON_TX_ARB_TIMEOUT_EN
            timeout_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
`ifdef BACK_ICON_TX_ARB_TIMEOUT_EN
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    assign bus.grant_o    = grant_q;
    assign bus.busy_eus_o = busy_q;
`ifdef BACK_ICON_TX_ARB_TIMEOUT_EN
    assign bus.timeout_o  = timeout_q;
`else
    assign bus.timeout_o  = '0;
`endif

endmodule

// File: tb/tb_back_icon_tx_arbiter.sv
// Testbench for back_icon_tx_arbiter: directed vector table, long-hold sequence, random run vs. model.
// Follows BACK_ICON_TX_ARB_TIMEOUT_EN the same way the design does.
module tb_back_icon_tx_arbiter;
    localparam int N    = 4;
    localparam int E    = 8;
    localparam int EW   = 3;
    localparam int MAXH = 15;
`ifdef BACK_ICON_TX_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    typedef logic [N-1:0][EW-1:0] idx_t;

    typedef struct {
        string        name;
        bit           rst_n;
        logic [N-1:0] valid;
        idx_t         idx;
        logic [N-1:0] done;
        logic [N-1:0] exp_grant;
        logic [E-1:0] exp_busy;
    } vec_t;

    logic clk;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];

    bit           m_owned [E];
    int           m_owner [E];
    int           m_rr    [E];
    int           m_hold  [E];
    logic [N-1:0] m_grant;
    logic [E-1:0] m_busy;
    logic [N-1:0] m_timeout;

    back_icon_tx_arbiter_if #(.NUM_ICON_CHANNELS(N), .NUM_EUS(E)) bus ();

    back_icon_tx_arbiter #(
        .NUM_ICON_CHANNELS(N),
        .NUM_EUS(E),
        .MAX_HOLD_CYCLES(MAXH)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic idx_t allIdx(int e);
        idx_t r;
        for (int ch = 0; ch < N; ch++) r[ch] = EW'(e);
        return r;
    endfunction

    function automatic idx_t mkIdx(int i3, int i2, int i1, int i0);
        return {EW'(i3), EW'(i2), EW'(i1), EW'(i0)};
    endfunction

    function automatic void addVec(string nm, bit rn, logic [N-1:0] v, idx_t ix,
                                   logic [N-1:0] dn, logic [N-1:0] eg, logic [E-1:0] eb);
        vec_t t;
        t.name = nm; t.rst_n = rn; t.valid = v; t.idx = ix;
        t.done = dn; t.exp_grant = eg; t.exp_busy = eb;
        vecs.push_back(t);
    endfunction

    function automatic bool_cand(int ch, int e);
        return bus.req_valid_i[ch] && (int'(bus.req_euidx_i[ch]) == e);
    endfunction

    // Earliest requester of EU e in cyclic order from start, skipping excl; -1 when none.
    function automatic int firstCand(int e, int start, int excl);
        int ch;
        for (int k = 0; k < N; k++) begin
            ch = (start + k) % N;
            if (ch != excl && bool_cand(ch, e)) return ch;
        end
        return -1;
    endfunction

    task automatic modelStep();
        int  c;
        int  o;
        bit  rel;
        bit  forced;
        m_timeout = '0;
        for (int e = 0; e < E; e++) begin
            if (!reset_n) begin
                m_owned[e] = 1'b0; m_owner[e] = 0; m_rr[e] = 0; m_hold[e] = 0;
            end else if (!m_owned[e]) begin
                c = firstCand(e, m_rr[e], -1);
                if (c >= 0) begin
                    m_owned[e] = 1'b1; m_owner[e] = c; m_hold[e] = 0;
                end
            end else begin
                o      = m_owner[e];
                rel    = !bool_cand(o, e) || bus.done_i[o];
                forced = TO_EN && !rel && (m_hold[e] == MAXH);
                if (rel || forced) begin
                    m_rr[e] = (o + 1) % N;
                    if (forced) m_timeout[o] = 1'b1;
                    c = firstCand(e, m_rr[e], o);
                    m_hold[e] = 0;
                    if (c >= 0) m_owner[e] = c;
                    else m_owned[e] = 1'b0;
                end else if (m_hold[e] < MAXH) begin
                    m_hold[e] = m_hold[e] + 1;
                end
            end
        end
        m_grant = '0;
        m_busy  = '0;
        for (int e = 0; e < E; e++) begin
            if (m_owned[e]) begin
                m_grant[m_owner[e]] = 1'b1;
                m_busy[e]           = 1'b1;
            end
        end
    endtask

    task automatic applyStimulus(bit rn, logic [N-1:0] v, idx_t ix, logic [N-1:0] dn);
        reset_n         = rn;
        bus.req_valid_i = v;
        bus.req_euidx_i = ix;
        bus.done_i      = dn;
        @(posedge clk);
        modelStep();
        #1;
    endtask

    task automatic checkOutput(string nm, logic [N-1:0] eg, logic [E-1:0] eb, logic [N-1:0] et);
        checks += 3;
        if (bus.grant_o !== eg) begin
            errors++;
            $display("[TB] FAIL %s grant_o got %b want %b", nm, bus.grant_o, eg);
        end
        if (bus.busy_eus_o !== eb) begin
            errors++;
            $display("[TB] FAIL %s busy_eus_o got %b want %b", nm, bus.busy_eus_o, eb);
        end
        if (bus.timeout_o !== et) begin
            errors++;
            $display("[TB] FAIL %s timeout_o got %b want %b", nm, bus.timeout_o, et);
        end
    endtask

    initial begin
        logic [N-1:0] v;
        logic [N-1:0] dn;
        logic [N-1:0] eg;
        logic [N-1:0] et;
        idx_t         ix;
        bit           rn;
        int           done_div;

        reset_n         = 1'b0;
        bus.req_valid_i = '1;
        bus.req_euidx_i = allIdx(5);
        bus.done_i      = '0;

        for (int i = 0; i < 3; i++) addVec("reset", 0, 4'b1111, allIdx(5), 4'b0000, 4'b0000, 8'h00);
        for (int i = 0; i < 4; i++) addVec("ch1_eu2", 1, 4'b0010, mkIdx(0,0,2,0), 4'b0000, 4'b0010, 8'b00000100);
        addVec("ch1_done",    1, 4'b0010, mkIdx(0,0,2,0), 4'b0010, 4'b0000, 8'h00);
        addVec("idle0",       1, 4'b0000, mkIdx(0,0,2,0), 4'b0000, 4'b0000, 8'h00);
        addVec("rr_ch0",      1, 4'b1011, allIdx(5), 4'b0000, 4'b0001, 8'b00100000);
        addVec("rr_ch0_hold", 1, 4'b1011, allIdx(5), 4'b0000, 4'b0001, 8'b00100000);
        addVec("rr_to_ch1",   1, 4'b1011, allIdx(5), 4'b0001, 4'b0010, 8'b00100000);
        addVec("rr_ch1_hold", 1, 4'b1011, allIdx(5), 4'b0000, 4'b0010, 8'b00100000);
        addVec("rr_to_ch3",   1, 4'b1011, allIdx(5), 4'b0010, 4'b1000, 8'b00100000);
        addVec("rr_ch3_hold", 1, 4'b1011, allIdx(5), 4'b0000, 4'b1000, 8'b00100000);
        addVec("rr_wrap_ch0", 1, 4'b1011, allIdx(5), 4'b1000, 4'b0001, 8'b00100000);
        addVec("rr_drop",     1, 4'b0000, allIdx(5), 4'b0000, 4'b0000, 8'h00);
        addVec("dual_grant",  1, 4'b0101, mkIdx(0,6,0,1), 4'b0000, 4'b0101, 8'b01000010);
        addVec("idle1",       1, 4'b0000, mkIdx(0,6,0,1), 4'b0000, 4'b0000, 8'h00);
        addVec("ch2_eu3",     1, 4'b0100, mkIdx(0,3,0,0), 4'b0000, 4'b0100, 8'b00001000);
        addVec("ch2_to_eu4",  1, 4'b0100, mkIdx(0,4,0,0), 4'b0000, 4'b0100, 8'b00010000);
        addVec("idle2",       1, 4'b0000, mkIdx(0,4,0,0), 4'b0000, 4'b0000, 8'h00);
        addVec("pre_rst",     1, 4'b0001, allIdx(0), 4'b0000, 4'b0001, 8'b00000001);
        addVec("mid_rst",     0, 4'b0001, allIdx(0), 4'b0000, 4'b0000, 8'h00);
        addVec("post_rst",    1, 4'b0001, allIdx(0), 4'b0000, 4'b0001, 8'b00000001);
        addVec("idle3",       1, 4'b0000, allIdx(0), 4'b0000, 4'b0000, 8'h00);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst_n, vecs[i].valid, vecs[i].idx, vecs[i].done);
            checkOutput(vecs[i].name, vecs[i].exp_grant, vecs[i].exp_busy, 4'b0000);
        end

        // ch0 sits on EU0 with no done while ch1 waits; the watchdog, if built in, alternates them every 16 cycles.
        applyStimulus(1, 4'b0001, allIdx(0), 4'b0000);
        checkOutput("hold_start", 4'b0001, 8'b00000001, 4'b0000);
        for (int k = 1; k <= 100; k++) begin
            applyStimulus(1, 4'b0011, allIdx(0), 4'b0000);
            eg = 4'b0001;
            et = 4'b0000;
            if (TO_EN) begin
                eg = ((k / 16) % 2 == 0) ? 4'b0001 : 4'b0010;
                if (k % 16 == 0) et = ((k / 16) % 2 == 0) ? 4'b0010 : 4'b0001;
            end
            checkOutput($sformatf("hold_k%0d", k), eg, 8'b00000001, et);
        end
        applyStimulus(1, 4'b0000, allIdx(0), 4'b0000);
        checkOutput("hold_release", 4'b0000, 8'h00, 4'b0000);

        v  = '0;
        ix = '0;
        for (int c = 0; c < 3000; c++) begin
            done_div = (c < 1500) ? 5 : 40;
            rn = ($urandom_range(0, 199) != 0);
            for (int ch = 0; ch < N; ch++) begin
                if ($urandom_range(0, 3) == 0) begin
                    v[ch]  = 1'($urandom_range(0, 1));
                    ix[ch] = EW'($urandom_range(0, 3));
                end
                dn[ch] = ($urandom_range(0, done_div - 1) == 0);
            end
            applyStimulus(rn, v, ix, dn);
            checkOutput("random", m_grant, m_busy, m_timeout);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
